fetch_sequencer: RTL

Instruction-fetch controller that owns the program counter and sequences the instruction memory. It drives the memory address, captures each returned word into an output register with a valid/ready handshake toward decode, and applies redirects from the branch unit. It also stops on a halt word and flags illegal targets. It replaces a free-running PC register plus loose PCNext wiring as the single source of fetch addresses.

---
 rtl/fetch_sequencer_if.sv | 21 ++
 rtl/fetch_sequencer.sv | 118 +++++++++++
 2 files changed

// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus: instruction-memory port, decode handshake and branch redirect.
interface fetch_sequencer_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_target;

    modport master (
        output imem_addr, instr, instr_pc, instr_valid,
        input  imem_data, instr_ready, redirect_valid, redirect_target
    );

    modport slave (
        input  imem_addr, instr, instr_pc, instr_valid,
        output imem_data, instr_ready, redirect_valid, redirect_target
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, captures memory words into a
// valid/ready output register for decode, and applies branch redirects.
module fetch_sequencer #(
    parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
    parameter int unsigned PC_STEP    = 4,
    parameter int unsigned ADDR_LIMIT = 256,
    parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              err,
    fetch_sequencer_if.master bus
);
    localparam logic [31:0] LIMIT   = 32'(ADDR_LIMIT);
    localparam logic [31:0] PC_MASK = 32'(ADDR_LIMIT - 1);
    localparam logic [31:0] STEP    = 32'(PC_STEP);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        HALTED,
        ERROR
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        adv;

    // A target must be word aligned and inside instruction memory.
    function automatic logic target_legal(input logic [31:0] t);
        return (t[1:0] == 2'b00) && (t < LIMIT);
    endfunction

    assign adv             = !instr_valid || bus.instr_ready;
    assign bus.imem_addr   = pc;
    assign bus.instr       = instr;
    assign bus.instr_pc    = instr_pc;
    assign bus.instr_valid = instr_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= BOOT_ADDR;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
        end else begin
            case (state)
                IDLE, HALTED: begin
                    instr_valid <= 1'b0;
                    if (start) begin
                        pc    <= BOOT_ADDR;
                        state <= FETCH;
                        busy  <= 1'b1;
                    end
                end
                FETCH: begin
                    // Redirect wins even over a stalled word; that word is dropped.
                    if (bus.redirect_valid) begin
                        instr_valid <= 1'b0;
                        if (target_legal(bus.redirect_target)) begin
                            pc <= bus.redirect_target;
                        end else begin
                            state <= ERROR;
                            err   <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end else if (adv) begin
                        instr       <= bus.imem_data;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        if (bus.imem_data == HALT_WORD) begin
                            state <= DRAIN;
                        end else begin
                            pc <= (pc + STEP) & PC_MASK;
                        end
                    end
                end
                DRAIN: begin
                    // Only the halt word is outstanding; wait for decode to take it.
                    if (bus.redirect_valid) begin
                        instr_valid <= 1'b0;
                        if (target_legal(bus.redirect_target)) begin
                            pc    <= bus.redirect_target;
                            state <= FETCH;
                        end else begin
                            state <= ERROR;
                            err   <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end else if (bus.instr_ready) begin
                        instr_valid <= 1'b0;
                        state       <= HALTED;
                        busy        <= 1'b0;
                    end
                end
                ERROR: begin
                    instr_valid <= 1'b0;
                    busy        <= 1'b0;
                    err         <= 1'b1;
                end
                default: begin
                    state       <= IDLE;
                    instr_valid <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end
endmodule
